// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared memory.
// The arbiter uses the slave modport; requesters and the memory use master.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  // Handshake: reqN is raised with weN/addrN/wdataN and held until ackN is
  // seen. ackN is a one-cycle completion pulse, and rdataN is valid while
  // ackN is high. The requester drops reqN on the edge at which it sees ackN.
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ce;
  logic              mem_r;
  logic              mem_oe;
  logic              mem_w;
  logic              mem_rst;
  logic              busy;
  logic              owner;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output ack0, rdata0, ack1, rdata1,
    output mem_addr, mem_wdata, mem_ce, mem_r, mem_oe, mem_w, mem_rst,
    output busy, owner
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_addr, mem_wdata, mem_ce, mem_r, mem_oe, mem_w, mem_rst,
    input  busy, owner
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter and access sequencer for the shared memory.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module mem_bus_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_bus_arbiter_if.slave     bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              owner_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              mem_rst_q;
  logic              any_req;
  logic              winner;
  logic              ce_c;
  logic              r_c;
  logic              oe_c;
  logic              w_c;
  logic              last_access;

  assign any_req     = bus.req0 | bus.req1;
  assign last_access = (state == ACCESS) && (wait_cnt == 4'd0);

  always_comb begin
    winner = owner_q;
`ifdef MEM_ARB_FIXED_PRIO_EN
    winner = bus.req0 ? 1'b0 : 1'b1;
`else
    // Contested grants go to the port that did not win last time.
    if (bus.req0 && bus.req1) winner = ~owner_q;
    else                      winner = ~bus.req0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ce_c      = 1'b0;
    r_c       = 1'b0;
    oe_c      = 1'b0;
    w_c       = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = SETUP;
      end
      SETUP: begin
        ce_c      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        ce_c = 1'b1;
        if (we_q) begin
          w_c = 1'b1;
        end else begin
          r_c  = 1'b1;
          oe_c = 1'b1;
        end
        if (wait_cnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are latched at the grant so later changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      owner_q   <= 1'b1;
      wait_cnt  <= 4'd0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      mem_rst_q <= 1'b1;
    end else begin
      mem_rst_q <= 1'b0;
      if (state == IDLE && any_req) begin
        addr_q  <= winner ? bus.addr1  : bus.addr0;
        wdata_q <= winner ? bus.wdata1 : bus.wdata0;
        we_q    <= winner ? bus.we1    : bus.we0;
        owner_q <= winner;
      end
      if (state == SETUP) begin
        wait_cnt <= WAIT_INIT;
      end else if (state == ACCESS && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (last_access && !we_q) begin
        if (owner_q) rdata1_q <= bus.mem_rdata;
        else         rdata0_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = we_q ? wdata_q : '0;
  assign bus.mem_ce    = ce_c;
  assign bus.mem_r     = r_c;
  assign bus.mem_oe    = oe_c;
  assign bus.mem_w     = w_c;
  assign bus.mem_rst   = mem_rst_q;
  assign bus.ack0      = (state == DONE) && !owner_q;
  assign bus.ack1      = (state == DONE) &&  owner_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.busy      = (state != IDLE);
  assign bus.owner     = owner_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed cases plus randomized rounds
// checked against a transaction-level model of arbitration and memory contents.
module tb_mem_bus_arbiter;
  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int WAITC = 1;
  localparam int EW    = 42;  // {port, we, addr[16], wdata[8], rdata0[8], rdata1[8]}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;

  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WAITC)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  // reference model
  logic [7:0] ref_mem [logic [15:0]];
  logic [7:0] ref_rd [2];
  logic       ref_owner;

  // memory model (owned by the monitor block)
  logic [7:0] mem_wr [logic [15:0]];

  int cnt_ce, cnt_r, cnt_oe, cnt_w;
  logic [EW-1:0] mon_h;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [7:0] mem_peek(input logic [15:0] a);
    return mem_wr.exists(a) ? mem_wr[a] : init_val(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Arbitration rule from the port's point of view.
  function automatic logic pick(input logic r0, input logic r1);
`ifdef MEM_ARB_FIXED_PRIO_EN
    return r0 ? 1'b0 : 1'b1;
`else
    if (r0 && r1) return ~ref_owner;
    return r0 ? 1'b0 : 1'b1;
`endif
  endfunction

  task automatic model_txn(input logic p, input logic we, input logic [15:0] a, input logic [7:0] wd);
    if (we) ref_mem[a] = wd;
    else    ref_rd[p] = ref_read(a);
    ref_owner = p;
    exp_q.push_back({p, we, a, wd, ref_rd[0], ref_rd[1]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic p, input logic we, input logic [15:0] a, input logic [7:0] wd);
    if (p) begin bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd; end
    else   begin bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd; end
  endtask

  task automatic drop_req(input logic p);
    if (p) bus.req1 = 1'b0;
    else   bus.req0 = 1'b0;
  endtask

  task automatic scramble(input logic p);
    if (p) begin
      bus.we1 = 1'($urandom_range(0, 1)); bus.addr1 = 16'($urandom); bus.wdata1 = 8'($urandom);
    end else begin
      bus.we0 = 1'($urandom_range(0, 1)); bus.addr0 = 16'($urandom); bus.wdata0 = 8'($urandom);
    end
  endtask

  // Counts negedges from the one on which the request was raised.
  task automatic wait_ack(input logic p, input logic early, output int n, output logic ok);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      n++;
      if (early && n == 1) begin
        drop_req(p);
        scramble(p);
      end
      ok = p ? bus.ack1 : bus.ack0;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ack%0d_timeout: got no ack, want ack within 40 cycles", p);
    end
  endtask

  task automatic port_proc(input logic p, input logic early, input logic chk_lat);
    int   n;
    logic ok;
    wait_ack(p, early, n, ok);
    if (ok && chk_lat) check(p ? "latency1" : "latency0", 64'(n), 64'(3 + WAITC));
    @(posedge clk);
    #1;
    drop_req(p);
  endtask

  task automatic do_single(input logic p, input logic we, input logic [15:0] a,
                           input logic [7:0] wd, input logic early);
    @(negedge clk);
    model_txn(p, we, a, wd);
    drive_req(p, we, a, wd);
    port_proc(p, early, 1'b1);
  endtask

  // ---------------- monitor + memory model ----------------
  always @(negedge clk) begin
    if (rst) begin
      cnt_ce = 0; cnt_r = 0; cnt_oe = 0; cnt_w = 0;
    end else begin
      check("ack_exclusive", 64'(bus.ack0 & bus.ack1), 64'd0);
      check("rw_exclusive", 64'(bus.mem_r & bus.mem_w), 64'd0);
      check("oe_with_r", 64'(bus.mem_oe), 64'(bus.mem_r));
      check("strobe_without_ce", 64'((bus.mem_r | bus.mem_w | bus.mem_oe) & ~bus.mem_ce), 64'd0);
      if (bus.mem_ce) cnt_ce++;
      if (bus.mem_r)  cnt_r++;
      if (bus.mem_oe) cnt_oe++;
      if (bus.mem_w)  cnt_w++;
      if (bus.mem_w) mem_wr[bus.mem_addr] = bus.mem_wdata;
      if (bus.mem_ce && exp_q.size() > 0) begin
        mon_h = exp_q[0];
        check("mem_addr", 64'(bus.mem_addr), 64'(mon_h[39:24]));
        if (bus.mem_w) check("mem_wdata", 64'(bus.mem_wdata), 64'(mon_h[23:16]));
      end
      if (bus.ack0 || bus.ack1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack0=%0d ack1=%0d, want none", bus.ack0, bus.ack1);
        end else begin
          mon_h = exp_q.pop_front();
          check("grant_port", 64'(bus.ack1), 64'(mon_h[41]));
          check("rdata0", 64'(bus.rdata0), 64'(mon_h[15:8]));
          check("rdata1", 64'(bus.rdata1), 64'(mon_h[7:0]));
          check("ce_cycles", 64'(cnt_ce), 64'(WAITC + 2));
          check("r_cycles",  64'(cnt_r),  mon_h[40] ? 64'd0 : 64'(WAITC + 1));
          check("oe_cycles", 64'(cnt_oe), mon_h[40] ? 64'd0 : 64'(WAITC + 1));
          check("w_cycles",  64'(cnt_w),  mon_h[40] ? 64'(WAITC + 1) : 64'd0);
        end
        cnt_ce = 0; cnt_r = 0; cnt_oe = 0; cnt_w = 0;
      end
    end
    bus.mem_rdata <= (bus.mem_r && bus.mem_oe) ? mem_peek(bus.mem_addr) : 8'h00;
  end

  // ---------------- stimulus ----------------
  logic       r0, r1, w, early;
  logic       t_we [2];
  logic [15:0] t_a [2];
  logic [7:0]  t_wd [2];
  int          n_acks;

  initial begin
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    ref_owner = 1'b1;
    ref_rd[0] = 8'h00;
    ref_rd[1] = 8'h00;

    // reset release with no requests
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mem_rst_high", 64'(bus.mem_rst), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_strobes", 64'({bus.mem_ce, bus.mem_r, bus.mem_oe, bus.mem_w}), 64'd0);
    check("rst_acks", 64'({bus.ack0, bus.ack1}), 64'd0);
    check("rst_owner", 64'(bus.owner), 64'd1);
    check("rst_rdata", 64'({bus.rdata0, bus.rdata1}), 64'd0);
    check("rst_mem_bus", 64'({bus.mem_addr, bus.mem_wdata}), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    @(posedge clk);
    #1 check("mem_rst_clears", 64'(bus.mem_rst), 64'd0);

    // directed transactions
    do_single(1'b1, 1'b1, 16'h0010, 8'hA5, 1'b0);
    do_single(1'b0, 1'b0, 16'h0010, 8'h00, 1'b0);
    do_single(1'b1, 1'b1, 16'h8001, 8'h3C, 1'b0);

    // both ports held through four grants
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      w = pick(1'b1, 1'b1);
      model_txn(w, 1'b0, w ? 16'h8001 : 16'h0010, 8'h00);
    end
    drive_req(1'b0, 1'b0, 16'h0010, 8'h00);
    drive_req(1'b1, 1'b0, 16'h8001, 8'h00);
    n_acks = 0;
    for (int c = 0; c < 100 && n_acks < 4; c++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) n_acks++;
    end
    check("contention_acks", 64'(n_acks), 64'd4);
    @(posedge clk);
    #1;
    drop_req(1'b0);
    drop_req(1'b1);

    // req dropped early still completes on time
    do_single(1'b0, 1'b0, 16'h8001, 8'h00, 1'b1);

    // reset during the ACCESS phase of a write
    @(negedge clk);
    drive_req(1'b0, 1'b1, 16'h0020, 8'h77);
    repeat (2) @(negedge clk);
    check("abort_w_before", 64'(bus.mem_w), 64'd1);
    #2;
    rst = 1'b1;
    bus.req0 = 1'b0;
    #1;
    check("abort_strobes", 64'({bus.mem_ce, bus.mem_r, bus.mem_oe, bus.mem_w}), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_ack", 64'({bus.ack0, bus.ack1}), 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    ref_owner = 1'b1;
    ref_rd[0] = 8'h00;
    ref_rd[1] = 8'h00;
    @(negedge clk);
    check("abort_mem_rst", 64'(bus.mem_rst), 64'd1);
    check("abort_owner", 64'(bus.owner), 64'd1);
    do_single(1'b0, 1'b0, 16'h0010, 8'h00, 1'b0);

    // randomized rounds
    for (int rnd = 0; rnd < 40; rnd++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      early = !(r0 && r1) && ($urandom_range(0, 3) == 0);
      for (int p = 0; p < 2; p++) begin
        t_we[p] = 1'($urandom_range(0, 1));
        t_a[p]  = 16'(($urandom_range(0, 3) << 14) | $urandom_range(0, 15));
        t_wd[p] = 8'($urandom);
      end
      if (r0 && r1) begin
        w = pick(1'b1, 1'b1);
        model_txn(w, t_we[w], t_a[w], t_wd[w]);
        model_txn(~w, t_we[~w], t_a[~w], t_wd[~w]);
      end else begin
        w = r1;
        model_txn(w, t_we[w], t_a[w], t_wd[w]);
      end
      if (r0) drive_req(1'b0, t_we[0], t_a[0], t_wd[0]);
      if (r1) drive_req(1'b1, t_we[1], t_a[1], t_wd[1]);
      fork
        begin if (r0) port_proc(1'b0, early, !(r0 && r1)); end
        begin if (r1) port_proc(1'b1, early, !(r0 && r1)); end
      join
    end

    repeat (6) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    foreach (ref_mem[a]) check("mem_contents", 64'(mem_peek(a)), 64'(ref_mem[a]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
